// File: rtl/shift_seq_if.sv
// Request/result handshake bundle for the sequential 32-bit right shifter.
interface shift_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_amt;
  logic        in_sra;
  logic        in_rotate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  modport master (
    output in_valid, in_a, in_amt, in_sra, in_rotate, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_a, in_amt, in_sra, in_rotate, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequential 32-bit right shifter: applies the 16/8/4/2/1 barrel layers one per clock.
// Rotate mode is built only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  shift_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  lyr_q, lyr_d;
  logic [4:0]  amt_q, amt_d;
  logic        fill_q, fill_d;
  logic [31:0] work_q, work_d;
  logic [31:0] out_data_q, out_data_d;
  logic [31:0] layer_res;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic        rot_q, rot_d;
`else
  logic        unused_rot;
  assign unused_rot = bus.in_rotate;
`endif

  // One layer of width 2^l: shift in the latched fill bit, or wrap the low bits around.
`ifdef SHIFT_SEQ_ROTATE_EN
  function automatic logic [31:0] shift_layer(input logic [31:0] w, input logic [2:0] l,
                                              input logic fill, input logic rot);
`else
  function automatic logic [31:0] shift_layer(input logic [31:0] w, input logic [2:0] l,
                                              input logic fill);
`endif
    logic [5:0]  sh;
    logic [31:0] res;
    sh  = 6'd1 << l;
    res = (w >> sh) | ({32{fill}} & ~(32'hFFFF_FFFF >> sh));
`ifdef SHIFT_SEQ_ROTATE_EN
    if (rot) res = (w >> sh) | (w << (6'd32 - sh));
`endif
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    lyr_d      = lyr_q;
    amt_d      = amt_q;
    fill_d     = fill_q;
    work_d     = work_q;
    out_data_d = out_data_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_d      = rot_q;
    layer_res  = shift_layer(work_q, lyr_q, fill_q, rot_q);
`else
    layer_res  = shift_layer(work_q, lyr_q, fill_q);
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_a;
          amt_d   = bus.in_amt;
          fill_d  = bus.in_sra & bus.in_a[31];
`ifdef SHIFT_SEQ_ROTATE_EN
          rot_d   = bus.in_rotate;
`endif
          lyr_d   = 3'd4;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (amt_q[lyr_q]) work_d = layer_res;
        // Fixed five-layer walk; the last layer also lands the result.
        if (lyr_q == 3'd0) begin
          out_data_d = work_d;
          state_d    = DONE;
        end else begin
          lyr_d = lyr_q - 3'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.out_data  = out_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lyr_q      <= 3'd0;
      amt_q      <= 5'd0;
      fill_q     <= 1'b0;
      work_q     <= 32'h0;
      out_data_q <= 32'h0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lyr_q      <= lyr_d;
      amt_q      <= amt_d;
      fill_q     <= fill_d;
      work_q     <= work_d;
      out_data_q <= out_data_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q      <= rot_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: directed corner cases followed by randomized requests
// checked against a plain-arithmetic shift/rotate model.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_seq_if bus ();

  shift_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void fail(input string name);
    n_chk++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endfunction

  // Reference: plain shift/rotate of the whole word by amt.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int amt,
                                            input bit sra, input bit rot);
    logic [63:0] dbl;
    if (amt == 0) return a;
    if (rot && ROT_EN) begin
      dbl = {a, a};
      return dbl[amt +: 32];
    end
    if (sra) return $signed(a) >>> amt;
    return a >> amt;
  endfunction

  // Monitor: pops one expectation per out_valid assertion, then checks the result holds.
  logic [31:0] held;
  bit          seen = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_out_valid");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("latency", 32'(cyc), 32'(e.due));
        end
        held = bus.out_data;
        seen = 1'b1;
      end else begin
        chk("out_data_hold", bus.out_data, held);
      end
    end else begin
      seen = 1'b0;
    end
  end

  // Called at a falling edge; returns at the falling edge after the capture edge.
  task automatic issue(input logic [31:0] a, input logic [4:0] amt, input bit sra,
                       input bit rot, input logic [31:0] exp);
    int g;
    exp_t e;
    g = 0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_amt    = amt;
    bus.in_sra    = sra;
    bus.in_rotate = rot;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) fail("in_ready_timeout");
    e.data = exp;
    e.due  = cyc + 6;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_txn(input bit rnd);
    int g;
    g = 0;
    while (g < 200) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        @(negedge clk);
        bus.out_ready = 1'b0;
        return;
      end
      @(negedge clk);
      g++;
    end
    fail("out_valid_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [4:0]  amt;
    bit          sra, rot;
    int          g;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'h0;
    bus.in_amt    = 5'd0;
    bus.in_sra    = 1'b0;
    bus.in_rotate = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'hF000_000F, 5'd4, 1'b0, 1'b0, 32'h0F00_0000);
    chk("busy_in_shift", 32'(bus.busy), 32'd1);
    chk("in_ready_in_shift", 32'(bus.in_ready), 32'd0);
    finish_txn(1'b0);
    issue(32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF);
    finish_txn(1'b0);
    issue(32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001);
    finish_txn(1'b0);
    issue(32'h1234_5678, 5'd8, 1'b0, 1'b1, ROT_EN ? 32'h7812_3456 : 32'h0012_3456);
    finish_txn(1'b0);
    issue(32'h8000_0001, 5'd0, 1'b1, 1'b0, 32'h8000_0001);
    finish_txn(1'b0);
    issue(32'h8765_4321, 5'd4, 1'b1, 1'b1, ROT_EN ? 32'h1876_5432 : 32'hF876_5432);
    finish_txn(1'b0);

    // Backpressure: result parked in DONE while a competing request is offered.
    issue(32'hA5A5_0000, 5'd16, 1'b0, 1'b0, 32'h0000_A5A5);
    g = 0;
    while (!bus.out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) fail("bp_out_valid_timeout");
    bus.in_valid = 1'b1;
    bus.in_a     = 32'hDEAD_BEEF;
    bus.in_amt   = 5'd3;
    repeat (10) begin
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
    chk("bp_out_data_kept", bus.out_data, 32'h0000_A5A5);

    // Asynchronous reset during the third layer cycle.
    issue(32'hFFFF_FFFF, 5'd17, 1'b0, 1'b0, 32'h0000_7FFF);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_out_data", bus.out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;
    issue(32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_000F);
    finish_txn(1'b0);

    for (int i = 0; i < 150; i++) begin
      a   = $urandom;
      amt = 5'($urandom_range(0, 31));
      sra = 1'($urandom_range(0, 1));
      rot = 1'($urandom_range(0, 1));
      if (i % 10 == 0) a = {1'b1, a[30:0]};
      issue(a, amt, sra, rot, ref_shift(a, int'(amt), sra, rot));
      finish_txn(1'b1);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
